inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction fetch front end for the single-cycle MIPS core. It sits between the instruction memory and the decode/execute datapath. It owns the fetch PC, issues word reads to a synchronous instruction memory with a fixed 1-cycle latency, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents them to the consumer on a valid/ready handshake, flushes on branch/jump/jr redirects, and raises `end_exec` when the loaded program has been fully fetched and drained.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 32'd0, fetch PC after reset
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_req  out  1  read request this cycle
- imem_addr  out  32  byte address of request, always word aligned
- imem_rdata  in  32  instruction word; valid the cycle after `imem_req`
- prog_words  in  32  number of instruction words loaded; fetch stops at PC>>2 >= prog_words
- inst  out  32  head instruction
- inst_pc  out  32  byte address of `inst`
- inst_valid  out  1  head entry present
- inst_ready  in  1  consumer accepts head this cycle
- redirect  in  1  taken branch/jump/jr; flush and refetch
- redirect_pc  in  32  new fetch target; bits [1:0] ignored
- end_exec  out  1  program fetched, queue empty, nothing in flight

## Operation
- Registers:
  - `fetch_pc` (32 b)
  - FIFO storage of {instruction, pc} with read/write pointers and `count` (log2(DEPTH)+1 b)
  - `inflight` (1 b): request issued last cycle, response due now
  - `state`
- FSM states: FETCH, STOPPED. Reset enters FETCH.
- FETCH:
  - Issue (`imem_req`=1, `imem_addr`=`fetch_pc`) when `count`+`inflight` < DEPTH, `redirect`=0, and (`fetch_pc`>>2) < `prog_words`.
  - On issue: `fetch_pc` += 4, modulo 2^32 (wrap from 32'hFFFFFFFC to 0 is legal).
  - Go to STOPPED when not issuing solely because (`fetch_pc`>>2) >= `prog_words`.
- STOPPED:
  - No issue.
  - `redirect` loads `fetch_pc` and returns to FETCH.
- Response: when `inflight`=1, push {`imem_rdata`, address issued} unless `redirect`=1 this cycle, in which case the response is dropped.
- Pop: when `inst_valid` && `inst_ready`. Simultaneous push and pop are legal; `count` is unchanged.
- Overflow is impossible by the issue rule. Pop on empty is ignored.
- Redirect takes priority over all other events:
  - Clears the FIFO; a pop requested in the same cycle is discarded.
  - `fetch_pc` <= {`redirect_pc`[31:2], 2'b00}.
  - No issue in the redirect cycle.
- `end_exec` = STOPPED && `count`==0 && `inflight`==0 (registered). Cleared by `redirect` or `reset`.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `inst`=0, `inst_pc`=0, `inst_valid`=0, `end_exec`=0
  - `fetch_pc`=RESET_PC, `count`=0, `inflight`=0
- A response in flight across `reset` is dropped.
- First request is in the first cycle after `reset` deasserts.
- Fetch latency:
  - request in cycle N
  - push at the end of N+1
  - `inst_valid`=1 in N+2 (no bypass)
- Redirect latency:
  - `redirect` in cycle R
  - request to `redirect_pc` in R+1
  - `inst_valid` with that instruction in R+3
  - `inst_valid`=0 during R+1 and R+2
- Throughput: 1 instruction/cycle sustained while `inst_ready`=1.
- With `inst_ready`=0: the queue fills to DEPTH, then `imem_req` stays 0.
- `end_exec` rises one cycle after the last entry is popped.

## Configuration
- FETCH_STATS_EN:
  - Defined: adds outputs `stat_fetched` (32 b, increments per pushed instruction) and `stat_flushed` (32 b, adds the number of entries discarded plus any dropped response per redirect). Both reset to 0 and saturate at 32'hFFFFFFFF.
  - Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Streaming: `prog_words`=8, memory word i = 32'h1000_0000+i, `inst_ready`=1 → `inst` 32'h10000000..32'h10000007 on consecutive cycles starting cycle 2, `inst_pc` 0..28, then `end_exec`=1 one cycle after the last pop.
- Backpressure: `inst_ready`=0 for 10 cycles → `count`=4, `imem_req`=0 after 4 issues. Release → 4 pops, then resumed fetch from PC 16 with no duplicates or gaps.
- Redirect with in-flight response: `redirect`=1, `redirect_pc`=32'h23 while `inflight`=1 and 2 entries queued → response dropped, `inst_valid`=0 for 2 cycles, next `inst_pc`=32'h20.
- Redirect plus pop plus push in the same cycle → FIFO empty next cycle, nothing from before the redirect ever appears.
- STOPPED recovery: after `end_exec`=1, `redirect_pc`=0 → `end_exec`=0 next cycle, refetch from 0. `reset` mid-stream → all outputs at reset values, first request at RESET_PC.
- With FETCH_STATS_EN: redirect flushing 3 entries and 1 in-flight response → `stat_flushed` += 4, `stat_fetched` counts only pushed words.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response, program size,
// consumer valid/ready handshake and redirect/end-of-program signalling.
interface inst_fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] prog_words;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        end_exec;

   modport master (
      output imem_req, imem_addr, inst, inst_pc, inst_valid, end_exec,
      input  imem_rdata, prog_words, inst_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, inst, inst_pc, inst_valid, end_exec,
      output imem_rdata, prog_words, inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, reads a 1-cycle-latency imem and queues
// {instruction, pc} pairs. Optional counters enabled by macro FETCH_STATS_EN.
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic clk,
   input  logic reset,
   inst_fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_flushed
`endif
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {FETCH = 1'b0, STOPPED = 1'b1} state_t;

   logic [31:0]   mem_inst_r [DEPTH];
   logic [31:0]   mem_pc_r   [DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AW:0]   count_r, count_s;
   logic          inflight_r, inflight_s;
   logic [31:0]   fetch_pc_r, fetch_pc_s, req_pc_r;
   state_t        state_r, state_s;
   logic          end_exec_r;
   logic          in_range_s, has_room_s, issue_s, push_s, pop_s, valid_s;
   logic          unused_s;

   assign unused_s   = ^bus.redirect_pc[1:0];
   assign in_range_s = ({2'b00, fetch_pc_r[31:2]} < bus.prog_words);
   assign has_room_s = ((count_r + {{AW{1'b0}}, inflight_r}) < DEPTH_C);
   assign valid_s    = (count_r != {(AW+1){1'b0}});

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_r <= FETCH;
      else       state_r <= state_s;
   end

   // Next-state: stop only when the program end is the sole reason not to issue
   always_comb begin
      state_s = state_r;
      case (state_r)
         FETCH: begin
            if (!bus.redirect && !in_range_s && has_room_s) state_s = STOPPED;
            else                                            state_s = FETCH;
         end
         STOPPED: begin
            if (bus.redirect) state_s = FETCH;
            else              state_s = STOPPED;
         end
         default: state_s = FETCH;
      endcase
   end

   // FSM outputs: issue decision
   always_comb begin
      issue_s = 1'b0;
      case (state_r)
         FETCH:   issue_s = !reset && !bus.redirect && in_range_s && has_room_s;
         STOPPED: issue_s = 1'b0;
         default: issue_s = 1'b0;
      endcase
   end

   // Queue bookkeeping; redirect flushes everything including a pending response
   always_comb begin
      push_s     = inflight_r && !bus.redirect;
      pop_s      = valid_s && bus.inst_ready && !bus.redirect;
      inflight_s = issue_s;
      if (bus.redirect) begin
         count_s    = {(AW+1){1'b0}};
         fetch_pc_s = {bus.redirect_pc[31:2], 2'b00};
      end else begin
         count_s    = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
         fetch_pc_s = issue_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_r <= RESET_PC;
         req_pc_r   <= RESET_PC;
         count_r    <= {(AW+1){1'b0}};
         inflight_r <= 1'b0;
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         end_exec_r <= 1'b0;
      end else begin
         fetch_pc_r <= fetch_pc_s;
         count_r    <= count_s;
         inflight_r <= inflight_s;
         end_exec_r <= (state_s == STOPPED) && (count_s == {(AW+1){1'b0}}) && !inflight_s;
         if (issue_s) req_pc_r <= fetch_pc_r;
         if (bus.redirect) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
         end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_inst_r[wr_ptr_r] <= bus.imem_rdata;
         mem_pc_r[wr_ptr_r]   <= req_pc_r;
      end
   end

   assign bus.imem_req   = issue_s;
   assign bus.imem_addr  = fetch_pc_r;
   assign bus.inst_valid = valid_s;
   assign bus.inst       = valid_s ? mem_inst_r[rd_ptr_r] : 32'd0;
   assign bus.inst_pc    = valid_s ? mem_pc_r[rd_ptr_r]   : 32'd0;
   assign bus.end_exec   = end_exec_r;

`ifdef FETCH_STATS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[32]) sat_add = 32'hFFFF_FFFF;
      else         sat_add = sum[31:0];
   endfunction

   logic [31:0] stat_fetched_r, stat_flushed_r;

   // Saturating fetch/flush counters; a flush counts queued entries plus a dropped response
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetched_r <= 32'd0;
         stat_flushed_r <= 32'd0;
      end else begin
         if (push_s) stat_fetched_r <= sat_add(stat_fetched_r, 32'd1);
         if (bus.redirect)
            stat_flushed_r <= sat_add(stat_flushed_r,
                                      {{(31-AW){1'b0}}, count_r} + {31'd0, inflight_r});
      end
   end

   assign stat_fetched = stat_fetched_r;
   assign stat_flushed = stat_flushed_r;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: expected {inst, pc} pairs are queued
// from the bench's own program image and compared as the consumer accepts them.
module tb_inst_fetch_queue;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
   } ent_t;
   ent_t exp_q[$];

   inst_fetch_queue_if bus ();

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched, stat_flushed;
   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .stat_fetched(stat_fetched), .stat_flushed(stat_flushed));
`else
   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
      .clk(clk), .reset(reset), .bus(bus));
`endif

   always #5 clk = ~clk;

   // instruction memory: word i holds 32'h1000_0000 + i, one cycle latency
   always @(posedge clk)
      if (bus.imem_req) bus.imem_rdata <= 32'h1000_0000 + {2'b00, bus.imem_addr[31:2]};

   function automatic ent_t word_at(input int idx);
      ent_t e;
      e.ins = 32'h1000_0000 + 32'(idx);
      e.pc  = 32'(idx) * 32'd4;
      return e;
   endfunction

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rdy, input logic redir, input logic [31:0] rpc);
      bus.inst_ready  = rdy;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
   endtask

   task automatic do_reset(input logic [31:0] pw);
      reset = 1'b1;
      bus.prog_words = pw;
      set_in(1'b0, 1'b0, 32'd0);
      to_next();
      to_next();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.prog_words = 32'd8;
      set_in(1'b1, 1'b0, 32'd0);
      to_next();
      to_next();
      to_neg();
      checks++;
      if ({bus.imem_req, bus.inst_valid, bus.end_exec} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: req/valid/end=%b, want 000", {bus.imem_req, bus.inst_valid, bus.end_exec});
      end
      checks++;
      if ({bus.imem_addr, bus.inst, bus.inst_pc} !== 96'd0) begin
         errors++;
         $display("FAIL reset_data: addr=%h inst=%h pc=%h, want all 0", bus.imem_addr, bus.inst, bus.inst_pc);
      end
      to_next();
   endtask

   task automatic test_streaming();
      ent_t e;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(word_at(i));
      for (int c = 0; c < 14; c++) begin
         to_neg();
         if (c == 0) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
               errors++;
               $display("FAIL stream_first_req: req=%b addr=%h, want 1 00000000", bus.imem_req, bus.imem_addr);
            end
         end
         checks++;
         if (bus.inst_valid !== (c >= 2 && c <= 9)) begin
            errors++;
            $display("FAIL stream_valid_c%0d: got %b, want %b", c, bus.inst_valid, (c >= 2 && c <= 9));
         end
         checks++;
         if (bus.end_exec !== (c >= 10)) begin
            errors++;
            $display("FAIL stream_end_exec_c%0d: got %b, want %b", c, bus.end_exec, (c >= 10));
         end
         if (bus.inst_valid && bus.inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra: pc=%h with no expected entry", bus.inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (bus.inst !== e.ins || bus.inst_pc !== e.pc) begin
                  errors++;
                  $display("FAIL stream_data: got %h@%h, want %h@%h", bus.inst, bus.inst_pc, e.ins, e.pc);
               end
            end
         end
         to_next();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL stream_missing: %0d entries never delivered, want 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      ent_t e;
      int   issues = 0;
      int   pops = 0;
      logic seen = 1'b0;
      logic [31:0] first_addr = 32'hDEAD_BEEF;
      do_reset(32'd16);
      for (int c = 0; c < 10; c++) begin
         to_neg();
         if (bus.imem_req) issues++;
         to_next();
      end
      to_neg();
      checks++;
      if (issues != 4 || bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL bp_issues: issued=%0d req=%b, want 4 and 0", issues, bus.imem_req);
      end
      for (int i = 0; i < 8; i++) exp_q.push_back(word_at(i));
      to_next();
      set_in(1'b1, 1'b0, 32'd0);
      for (int c = 0; c < 30 && pops < 8; c++) begin
         to_neg();
         if (bus.imem_req && !seen) begin
            seen = 1'b1;
            first_addr = bus.imem_addr;
         end
         if (bus.inst_valid && bus.inst_ready) begin
            pops++;
            checks++;
            e = exp_q.pop_front();
            if (bus.inst !== e.ins || bus.inst_pc !== e.pc) begin
               errors++;
               $display("FAIL bp_data: got %h@%h, want %h@%h", bus.inst, bus.inst_pc, e.ins, e.pc);
            end
         end
         to_next();
      end
      checks++;
      if (pops != 8) begin
         errors++;
         $display("FAIL bp_timeout: popped %0d, want 8", pops);
      end
      checks++;
      if (first_addr !== 32'd16) begin
         errors++;
         $display("FAIL bp_resume_pc: got %h, want 00000010", first_addr);
      end
   endtask

   task automatic test_redirect_inflight();
      ent_t e;
      do_reset(32'd16);
      for (int c = 0; c < 3; c++) to_next();
      set_in(1'b0, 1'b1, 32'h23);
      to_neg();
      checks++;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL redir_no_issue: req=%b, want 0", bus.imem_req);
      end
      to_next();
      set_in(1'b1, 1'b0, 32'd0);
      for (int i = 8; i < 12; i++) exp_q.push_back(word_at(i));
      for (int c = 1; c <= 6; c++) begin
         to_neg();
         if (c == 1) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin
               errors++;
               $display("FAIL redir_target: req=%b addr=%h, want 1 00000020", bus.imem_req, bus.imem_addr);
            end
         end
         if (c <= 3) begin
            checks++;
            if (bus.inst_valid !== (c == 3)) begin
               errors++;
               $display("FAIL redir_valid_r%0d: got %b, want %b", c, bus.inst_valid, (c == 3));
            end
         end
         if (bus.inst_valid && bus.inst_ready) begin
            checks++;
            e = exp_q.pop_front();
            if (bus.inst !== e.ins || bus.inst_pc !== e.pc) begin
               errors++;
               $display("FAIL redir_data: got %h@%h, want %h@%h", bus.inst, bus.inst_pc, e.ins, e.pc);
            end
         end
         to_next();
      end
   endtask

   task automatic test_redirect_pop_push();
      ent_t e;
      int   pops = 0;
      do_reset(32'd16);
      set_in(1'b1, 1'b0, 32'd0);
      exp_q.push_back(word_at(0));
      exp_q.push_back(word_at(1));
      for (int c = 0; c < 4; c++) begin
         to_neg();
         if (bus.inst_valid) begin
            checks++;
            e = exp_q.pop_front();
            if (bus.inst_pc !== e.pc) begin
               errors++;
               $display("FAIL rpp_pre: pc=%h, want %h", bus.inst_pc, e.pc);
            end
         end
         to_next();
      end
      // cycle 4: head valid and being accepted, response arriving, redirect asserted
      set_in(1'b1, 1'b1, 32'h30);
      to_neg();
      to_next();
      set_in(1'b1, 1'b0, 32'd0);
      to_neg();
      checks++;
      if (bus.inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL rpp_empty: inst_valid=%b, want 0", bus.inst_valid);
      end
      to_next();
      for (int i = 12; i < 16; i++) exp_q.push_back(word_at(i));
      for (int c = 0; c < 12; c++) begin
         to_neg();
         if (bus.inst_valid && bus.inst_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rpp_extra: pc=%h with no expected entry", bus.inst_pc);
            end else begin
               e = exp_q.pop_front();
               if (bus.inst !== e.ins || bus.inst_pc !== e.pc) begin
                  errors++;
                  $display("FAIL rpp_data: got %h@%h, want %h@%h", bus.inst, bus.inst_pc, e.ins, e.pc);
               end
            end
         end
         to_next();
      end
      to_neg();
      checks++;
      if (pops != 4 || bus.end_exec !== 1'b1) begin
         errors++;
         $display("FAIL rpp_end: pops=%0d end_exec=%b, want 4 and 1", pops, bus.end_exec);
      end
      to_next();
   endtask

   task automatic test_stopped_recovery();
      set_in(1'b1, 1'b1, 32'd0);
      to_next();
      set_in(1'b1, 1'b0, 32'd0);
      to_neg();
      checks++;
      if (bus.end_exec !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
         errors++;
         $display("FAIL recover: end=%b req=%b addr=%h, want 0 1 00000000", bus.end_exec, bus.imem_req, bus.imem_addr);
      end
      to_next();
      to_next();
      to_neg();
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd0 || bus.inst !== 32'h1000_0000) begin
         errors++;
         $display("FAIL recover_data: valid=%b %h@%h, want 1 10000000@00000000", bus.inst_valid, bus.inst, bus.inst_pc);
      end
      to_next();
      // reset mid-stream with a response in flight
      reset = 1'b1;
      to_next();
      to_neg();
      checks++;
      if ({bus.imem_req, bus.inst_valid, bus.end_exec} !== 3'b000 ||
          {bus.imem_addr, bus.inst, bus.inst_pc} !== 96'd0) begin
         errors++;
         $display("FAIL midreset: req=%b valid=%b end=%b addr=%h inst=%h pc=%h, want all 0",
                  bus.imem_req, bus.inst_valid, bus.end_exec, bus.imem_addr, bus.inst, bus.inst_pc);
      end
      to_next();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         to_neg();
         if (c == 0) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
               errors++;
               $display("FAIL midreset_req: req=%b addr=%h, want 1 00000000", bus.imem_req, bus.imem_addr);
            end
         end
         checks++;
         if (bus.inst_valid !== (c == 2) || (c == 2 && bus.inst_pc !== 32'd0)) begin
            errors++;
            $display("FAIL midreset_valid_c%0d: valid=%b pc=%h", c, bus.inst_valid, bus.inst_pc);
         end
         to_next();
      end
   endtask

`ifdef FETCH_STATS_EN
   task automatic test_stats();
      do_reset(32'd16);
      for (int c = 0; c < 4; c++) to_next();
      set_in(1'b0, 1'b1, 32'd0);
      to_next();
      set_in(1'b0, 1'b0, 32'd0);
      to_neg();
      checks++;
      if (stat_flushed !== 32'd4 || stat_fetched !== 32'd3) begin
         errors++;
         $display("FAIL stats: flushed=%0d fetched=%0d, want 4 and 3", stat_flushed, stat_fetched);
      end
      to_next();
   endtask
`endif

   initial begin
      bus.imem_rdata = 32'd0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_pop_push();
      test_stopped_recovery();
`ifdef FETCH_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
